stopwatch_counter: RTL

BCD minutes:seconds counting core of the stopwatch. Sits between the clock-divider/debouncer front end and the seven-segment display multiplexer. Consumes single-cycle tick enables and the debounced pause level. Produces four registered BCD digits (MM:SS) that the display stage scans, plus a run/pause status.

---
 rtl/stopwatch_counter.sv | 102 ++++++++++
 1 files changed

// File: rtl/stopwatch_counter.sv
// BCD MM:SS stopwatch core: 1 Hz counting with carry/wrap, 2 Hz field adjust,
// and a pause toggle driven by the rising edge of a debounced button level.
module stopwatch_counter #(
   parameter int unsigned MAX_MIN = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       tick_2hz,
   input  logic       pause_btn,
   input  logic       sel,
   input  logic       adj,
   output logic [3:0] min_10s,
   output logic [3:0] min_1s,
   output logic [3:0] sec_10s,
   output logic [3:0] sec_1s,
   output logic       paused,
   output logic       rollover
);

   localparam logic [3:0] MaxTens = 4'(MAX_MIN / 10);
   localparam logic [3:0] MaxOnes = 4'(MAX_MIN % 10);

   logic [7:0] r_min;
   logic [7:0] r_sec;
   logic       r_paused;
   logic       r_rollover;
   logic       r_pause_prev;

   logic [7:0] w_min_d;
   logic [7:0] w_sec_d;
   logic       w_paused_d;
   logic       w_rollover_d;
   logic       w_pause_rise;
   logic       w_sec_max;
   logic       w_min_max;

   // Two-digit BCD increment without wrap; callers handle the field limit.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) begin
         return {v[7:4] + 4'd1, 4'd0};
      end
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   assign w_pause_rise = pause_btn & ~r_pause_prev;
   assign w_sec_max    = (r_sec == 8'h59);
   assign w_min_max    = (r_min == {MaxTens, MaxOnes});

   always_comb begin
      w_min_d      = r_min;
      w_sec_d      = r_sec;
      w_rollover_d = 1'b0;
      // Toggle is independent of mode; counting below uses the pre-toggle state.
      w_paused_d   = r_paused ^ w_pause_rise;
      if (adj) begin
         if (tick_2hz) begin
            if (sel) begin
               w_sec_d = w_sec_max ? 8'h00 : bcd_inc(r_sec);
            end else begin
               w_min_d = w_min_max ? 8'h00 : bcd_inc(r_min);
            end
         end
      end else if (!r_paused && tick_1hz) begin
         if (w_sec_max) begin
            w_sec_d = 8'h00;
            if (w_min_max) begin
               w_min_d      = 8'h00;
               w_rollover_d = 1'b1;
            end else begin
               w_min_d = bcd_inc(r_min);
            end
         end else begin
            w_sec_d = bcd_inc(r_sec);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_min        <= 8'h00;
         r_sec        <= 8'h00;
         r_paused     <= 1'b0;
         r_rollover   <= 1'b0;
         r_pause_prev <= 1'b0;
      end else begin
         r_min        <= w_min_d;
         r_sec        <= w_sec_d;
         r_paused     <= w_paused_d;
         r_rollover   <= w_rollover_d;
         r_pause_prev <= pause_btn;
      end
   end

   assign min_10s  = r_min[7:4];
   assign min_1s   = r_min[3:0];
   assign sec_10s  = r_sec[7:4];
   assign sec_1s   = r_sec[3:0];
   assign paused   = r_paused;
   assign rollover = r_rollover;

endmodule
